// File: rtl/life_bank_ctrl.sv
// life_bank_ctrl: run/pause/clear sequencer for the Game-of-Life ping-pong cell RAMs.
// Issues one generation per tick to the Round engine, swaps read/write banks only in
// vblank after a generation completes, and sweeps a fill value into all banks on clear.
// Optional build macro: LIFE_SEED_LFSR_EN selects a pseudo-random LFSR fill instead of
// an all-alive fill.
module life_bank_ctrl #(
  parameter int ADDR_W   = 24,
  parameter int CELLS    = 120000,
  parameter int TICK_DIV = 5000000
) (
  input  logic              clk_vga,
  input  logic              reset_btn,
  input  logic              start_btn,
  input  logic              pause_btn,
  input  logic              vblank_pulse,
  input  logic              evo_done,
  output logic              evo_start,
  output logic              bank_sel,
  output logic              init_wren,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_data,
  output logic [1:0]        state,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       gen_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  state_t            state_q;
  logic              start_q;
  logic              pause_q;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_pend;
  logic              swap_pend;

  logic start_rise;
  logic pause_rise;
  logic tick_hit;
  logic launch;
  logic done_ok;
  logic do_swap;

  // A tick that expires this cycle can launch immediately; a blocked tick waits in
  // tick_pend (one deep). A pause edge in the same cycle suppresses the launch.
  assign start_rise = start_btn & ~start_q;
  assign pause_rise = pause_btn & ~pause_q;
  assign tick_hit   = (state_q == ST_RUN) && (tick_cnt == TICK_LAST);
  assign launch     = (state_q == ST_RUN) && !pause_rise && (tick_pend || tick_hit)
                      && !busy && !swap_pend;
  assign done_ok    = evo_done && busy;
  assign do_swap    = vblank_pulse && (swap_pend || done_ok);

  assign state = state_q;

  // Main sequencer: mode FSM, clear sweep, tick counter, launch/complete/swap bookkeeping.
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      tick_cnt  <= '0;
      tick_pend <= 1'b0;
      swap_pend <= 1'b0;
      evo_start <= 1'b0;
      bank_sel  <= 1'b0;
      init_wren <= 1'b0;
      init_addr <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      gen_count <= '0;
    end else begin
      start_q   <= start_btn;
      pause_q   <= pause_btn;
      evo_start <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            state_q   <= ST_CLEAR;
            bank_sel  <= 1'b0;
            gen_count <= '0;
            overrun   <= 1'b0;
            init_addr <= '0;
            init_wren <= 1'b1;
            tick_cnt  <= '0;
            tick_pend <= 1'b0;
            swap_pend <= 1'b0;
            busy      <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (init_addr == LAST_ADDR) begin
            init_wren <= 1'b0;
            init_addr <= '0;
            state_q   <= ST_RUN;
          end else begin
            init_addr <= init_addr + ADDR_ONE;
          end
        end
        ST_RUN: begin
          if (pause_rise) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_rise) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (state_q == ST_RUN) begin
        tick_cnt <= tick_hit ? '0 : (tick_cnt + TICK_ONE);
      end

      if (launch) begin
        tick_pend <= 1'b0;
      end else if (tick_hit) begin
        tick_pend <= 1'b1;
      end

      if (tick_hit && (tick_pend || busy || swap_pend)) begin
        overrun <= 1'b1;
      end

      if (launch) begin
        evo_start <= 1'b1;
        busy      <= 1'b1;
      end else if (done_ok) begin
        busy <= 1'b0;
      end

      if (do_swap) begin
        swap_pend <= 1'b0;
        bank_sel  <= ~bank_sel;
        gen_count <= gen_count + 16'd1;
      end else if (done_ok) begin
        swap_pend <= 1'b1;
      end
    end
  end

`ifdef LIFE_SEED_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Fill pattern generator: reseeded on each clear so every fill is identical.
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      lfsr <= LFSR_SEED;
    end else if ((state_q == ST_IDLE) && start_rise) begin
      lfsr <= LFSR_SEED;
    end else if (init_wren) begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  assign init_data = init_wren & lfsr[0];
`else
  assign init_data = init_wren;
`endif

endmodule
